// File: rtl/clock_divider.sv
// clock_divider: derives a one-cycle tick every div_q clocks and a 50%-duty
// square wave clk_div toggling on every tick.
// Start/stop command interface.
// The optional tick counter output tick_cnt is enabled by defining TICK_COUNT_EN.
//
// state | meaning
// IDLE  | halted, outputs quiet, waiting for start
// RUN   | counting clocks, emitting tick / clk_div

module clock_divider #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic [WIDTH-1:0] div,
   output logic             busy,
   output logic             tick,
`ifdef TICK_COUNT_EN
   output logic [CNT_W-1:0] tick_cnt,
`endif
   output logic             clk_div
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] div_q, div_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             tick_q, tick_d;
   logic             clk_div_q, clk_div_d;
   logic             busy_q, busy_d;

   // next-state and next-output decode
   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      cnt_d     = cnt_q;
      tick_d    = 1'b0;
      clk_div_d = clk_div_q;
      busy_d    = busy_q;
      case (state_q)
         IDLE: begin
            // stop alone is ignored here; start wins over a simultaneous stop
            if (start) begin
               state_d   = RUN;
               div_d     = (div == '0) ? ONE : div;
               cnt_d     = '0;
               busy_d    = 1'b1;
               clk_div_d = 1'b0;
            end
         end
         RUN: begin
            // stop suppresses a tick that would fall on the same edge
            if (stop) begin
               state_d   = IDLE;
               cnt_d     = '0;
               clk_div_d = 1'b0;
               busy_d    = 1'b0;
            end else if (cnt_q == div_q - ONE) begin
               tick_d    = 1'b1;
               cnt_d     = '0;
               clk_div_d = ~clk_div_q;
            end else begin
               cnt_d     = cnt_q + ONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // state and output registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         div_q     <= '0;
         cnt_q     <= '0;
         tick_q    <= 1'b0;
         clk_div_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         cnt_q     <= cnt_d;
         tick_q    <= tick_d;
         clk_div_q <= clk_div_d;
         busy_q    <= busy_d;
      end
   end

   assign busy    = busy_q;
   assign tick    = tick_q;
   assign clk_div = clk_div_q;

`ifdef TICK_COUNT_EN
   logic [CNT_W-1:0] tick_cnt_q;

   // counts cycles with tick high, saturating; cleared by an accepted start
   always_ff @(posedge clock) begin
      if (reset) begin
         tick_cnt_q <= '0;
      end else if (state_q == IDLE && start) begin
         tick_cnt_q <= '0;
      end else if (tick_q && tick_cnt_q != '1) begin
         tick_cnt_q <= tick_cnt_q + CNT_W'(1);
      end
   end

   assign tick_cnt = tick_cnt_q;
`endif

endmodule
